// File: rtl/switch_drain_arbiter.sv
// -----------------------------------------------------------------------------
// switch_drain_arbiter
// Round-robin drain scheduler for the switch egress side. Grants one ready port
// at a time with a one-hot port_read_o, collects the burst the port returns and
// re-emits it as a single stream tagged with source port, sop and eop.
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   arb_en_i       enables new grants (a burst in progress always completes)
//   port_ready_i   per-port data-available flags
//   read_out_i     granted port presents a valid word this cycle
//   port_data_i    {port_out_N-1, ..., port_out_0}, WORD_WIDTH bits each
//   port_read_o    one-hot registered grant
//   out_valid_o    out_data_o/out_port_o/out_sop_o/out_eop_o valid
//   out_data_o     drained word
//   out_port_o     source port of out_data_o
//   out_sop_o      first word of a burst
//   out_eop_o      last word of a burst
//   busy_o         FSM not in IDLE
//   timeout_err_o  one-cycle pulse when a grant is abandoned
//
// Optional feature: define SW_ARB_TIMEOUT_EN to abandon a grant whose first
// word does not arrive within TIMEOUT_CYCLES. Without it the block waits
// indefinitely and timeout_err_o is tied low.
//
// state | meaning
// IDLE  | waiting for arb_en_i and a ready port
// DRAIN | grant active, capturing words from the granted port
// FLUSH | grant released, emitting the held last word, advancing rr_ptr
// -----------------------------------------------------------------------------
module switch_drain_arbiter #(
    parameter int NUM_OF_PORTS   = 4,
    parameter int WORD_WIDTH     = 8,
    parameter int MAX_BURST      = 64,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int PW = (NUM_OF_PORTS > 1) ? $clog2(NUM_OF_PORTS) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               arb_en_i,
    input  logic [NUM_OF_PORTS-1:0]            port_ready_i,
    input  logic                               read_out_i,
    input  logic [NUM_OF_PORTS*WORD_WIDTH-1:0] port_data_i,
    output logic [NUM_OF_PORTS-1:0]            port_read_o,
    output logic                               out_valid_o,
    output logic [WORD_WIDTH-1:0]              out_data_o,
    output logic [PW-1:0]                      out_port_o,
    output logic                               out_sop_o,
    output logic                               out_eop_o,
    output logic                               busy_o,
    output logic                               timeout_err_o
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH} state_e;

    state_e                    state_q, state_d;
    logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]             grant_q, grant_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0]     hold_q, hold_d;
    logic                      hold_vld_q, hold_vld_d;
    logic                      sop_pend_q, sop_pend_d;
    logic [NUM_OF_PORTS-1:0]   port_read_q, port_read_d;
    logic                      out_valid_q, out_valid_d;
    logic [WORD_WIDTH-1:0]     out_data_q, out_data_d;
    logic [PW-1:0]             out_port_q, out_port_d;
    logic                      out_sop_q, out_sop_d;
    logic                      out_eop_q, out_eop_d;
    logic                      tmo_q, tmo_d;

    logic                      sel_found;
    logic [PW-1:0]             sel_idx;
    logic [PW:0]               scan_idx;
    logic                      burst_last;
    logic                      timeout_hit;
    logic [PW-1:0]             next_ptr;

`ifdef SW_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wait_q, wait_d;

    assign timeout_hit = !read_out_i && (cnt_q == '0) && (wait_q == WW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // First ready port scanning upward from rr_ptr with wrap.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_OF_PORTS; i++) begin
            scan_idx = {1'b0, rr_ptr_q} + (PW+1)'(i);
            if (scan_idx >= (PW+1)'(NUM_OF_PORTS))
                scan_idx = scan_idx - (PW+1)'(NUM_OF_PORTS);
            if (!sel_found && port_ready_i[scan_idx[PW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx[PW-1:0];
            end
        end
    end

    assign burst_last = read_out_i && (cnt_q == CW'(MAX_BURST - 1));
    assign next_ptr   = (grant_q == PW'(NUM_OF_PORTS - 1)) ? '0 : grant_q + PW'(1);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arb_en_i && sel_found) state_d = S_DRAIN;
            S_DRAIN: begin
                if (read_out_i) begin
                    if (burst_last) state_d = S_FLUSH;
                end else if (cnt_q != '0) begin
                    state_d = S_FLUSH;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next-state logic. A word leaves the hold register
    // one edge after capture, so every word appears two cycles after its
    // read_out_i; the final word leaves either on the read_out_i drop (DRAIN)
    // or, after a MAX_BURST cut-off, in FLUSH.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        sop_pend_d  = sop_pend_q;
        port_read_d = port_read_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        out_sop_d   = 1'b0;
        out_eop_d   = 1'b0;
        tmo_d       = 1'b0;
`ifdef SW_ARB_TIMEOUT_EN
        wait_d      = wait_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_en_i && sel_found) begin
                    grant_d     = sel_idx;
                    port_read_d = NUM_OF_PORTS'(1) << sel_idx;
                    cnt_d       = '0;
                    hold_vld_d  = 1'b0;
                    sop_pend_d  = 1'b1;
`ifdef SW_ARB_TIMEOUT_EN
                    wait_d      = '0;
`endif
                end
            end
            S_DRAIN: begin
                if (read_out_i) begin
                    if (hold_vld_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = hold_q;
                        out_port_d  = grant_q;
                        out_sop_d   = sop_pend_q;
                        sop_pend_d  = 1'b0;
                    end
                    hold_d     = port_data_i[grant_q*WORD_WIDTH +: WORD_WIDTH];
                    hold_vld_d = 1'b1;
                    cnt_d      = cnt_q + CW'(1);
                    if (burst_last) port_read_d = '0;
                end else if (cnt_q != '0) begin
                    port_read_d = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = hold_q;
                    out_port_d  = grant_q;
                    out_sop_d   = sop_pend_q;
                    out_eop_d   = 1'b1;
                    sop_pend_d  = 1'b0;
                    hold_vld_d  = 1'b0;
                end else if (timeout_hit) begin
                    port_read_d = '0;
                    tmo_d       = 1'b1;
                    rr_ptr_d    = next_ptr;
                end else begin
`ifdef SW_ARB_TIMEOUT_EN
                    wait_d = wait_q + WW'(1);
`endif
                end
            end
            S_FLUSH: begin
                if (hold_vld_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = hold_q;
                    out_port_d  = grant_q;
                    out_sop_d   = sop_pend_q;
                    out_eop_d   = 1'b1;
                    sop_pend_d  = 1'b0;
                end
                hold_vld_d = 1'b0;
                rr_ptr_d   = next_ptr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            sop_pend_q  <= 1'b0;
            port_read_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            sop_pend_q  <= sop_pend_d;
            port_read_q <= port_read_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            tmo_q       <= tmo_d;
        end
    end

`ifdef SW_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wait_q <= '0;
        else         wait_q <= wait_d;
    end
`endif

    assign port_read_o   = port_read_q;
    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign out_port_o    = out_port_q;
    assign out_sop_o     = out_sop_q;
    assign out_eop_o     = out_eop_q;
    assign busy_o        = (state_q != S_IDLE);
    assign timeout_err_o = tmo_q;

endmodule

// File: tb/tb_switch_drain_arbiter.sv
// -----------------------------------------------------------------------------
// tb_switch_drain_arbiter
// Directed bench for switch_drain_arbiter. A port responder answers each grant
// with a per-port number of words; a monitor logs outputs, grant edges and
// timeout pulses with their cycle numbers; the main sequence compares the logs
// against hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_switch_drain_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           arb_en;
    logic [N-1:0]   port_ready;
    logic           read_out;
    logic [N*W-1:0] port_data;
    logic [N-1:0]   port_read;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_port;
    logic           out_sop;
    logic           out_eop;
    logic           busy;
    logic           timeout_err;

    switch_drain_arbiter dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .arb_en_i      (arb_en),
        .port_ready_i  (port_ready),
        .read_out_i    (read_out),
        .port_data_i   (port_data),
        .port_read_o   (port_read),
        .out_valid_o   (out_valid),
        .out_data_o    (out_data),
        .out_port_o    (out_port),
        .out_sop_o     (out_sop),
        .out_eop_o     (out_eop),
        .busy_o        (busy),
        .timeout_err_o (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- port responder ----------------
    int rsp_len [N];
    int rsp_cnt = 0;
    int drv_cyc [$];
    int drv_port[$];

    function automatic logic [W-1:0] word_val(input int k);
        return W'((k + 1) * 17);
    endfunction

    always @(negedge clk) begin
        int p;
        p = 0;
        for (int i = 0; i < N; i++) if (port_read[i]) p = i;
        if (!rst_n || port_read == '0) begin
            rsp_cnt   = 0;
            read_out  = 1'b0;
            port_data = '0;
        end else if (rsp_cnt < rsp_len[p]) begin
            read_out  = 1'b1;
            port_data = {N{~word_val(rsp_cnt)}};
            port_data[p*W +: W] = word_val(rsp_cnt);
            drv_cyc.push_back(cyc);
            drv_port.push_back(p);
            rsp_cnt++;
        end else begin
            read_out = 1'b0;
        end
    end

    // ---------------- monitor ----------------
    int         mon_cyc [$];
    logic [7:0] mon_data[$];
    int         mon_port[$];
    logic [1:0] mon_se  [$];
    logic [3:0] gr_val  [$];
    int         gr_cyc  [$];
    int         fall_cyc[$];
    int         tmo_cyc [$];
    logic [3:0] prev_pr = '0;

    always @(negedge clk) begin
        if (out_valid) begin
            mon_cyc.push_back(cyc);
            mon_data.push_back(out_data);
            mon_port.push_back(int'(out_port));
            mon_se.push_back({out_sop, out_eop});
        end
        if (timeout_err) tmo_cyc.push_back(cyc);
        if (port_read != '0 && prev_pr == '0) begin
            gr_val.push_back(port_read);
            gr_cyc.push_back(cyc);
        end
        if (port_read == '0 && prev_pr != '0) fall_cyc.push_back(cyc);
        prev_pr = port_read;
    end

    task automatic clear_logs();
        drv_cyc.delete(); drv_port.delete();
        mon_cyc.delete(); mon_data.delete(); mon_port.delete(); mon_se.delete();
        gr_val.delete(); gr_cyc.delete(); fall_cyc.delete(); tmo_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 1'b0; arb_en = 1'b0; port_ready = '0;
        repeat (3) @(negedge clk);
        #1;
        clear_logs();
        rst_n = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n);
        int k;
        k = 0;
        while (gr_val.size() < n && k < 300) begin
            @(negedge clk); #1;
            k++;
        end
        if (gr_val.size() < n) check_vec("grant_wait_expired", gr_val.size(), n);
    endtask

    initial begin
        int c0;
        int k;
        logic [3:0] exp_gr[5];
        int         exp_p [5];

        rst_n = 1'b0; arb_en = 1'b0; port_ready = '0;
        for (int i = 0; i < N; i++) rsp_len[i] = 0;

        // ---- reset state ----
        cycles(3);
        check_vec("rst_port_read", port_read, 4'b0000);
        check_vec("rst_out_valid", out_valid, 0);
        check_vec("rst_out_data",  out_data,  0);
        check_vec("rst_busy",      busy,      0);
        check_vec("rst_timeout",   timeout_err, 0);
        clear_logs();
        rst_n = 1'b1;
        cycles(2);

        // ---- T1: port 2, 3-word burst ----
        rsp_len[2] = 3;
        arb_en = 1'b1; port_ready = 4'b0100; c0 = cyc;
        wait_grants(1);
        port_ready = '0;
        cycles(10);
        if (gr_val.size() >= 1) begin
            check_vec("t1_grant",     gr_val[0], 4'b0100);
            check_vec("t1_grant_cyc", gr_cyc[0], c0 + 1);
        end
        check_vec("t1_count", mon_cyc.size(), 3);
        for (int i = 0; i < 3 && i < mon_cyc.size() && i < drv_cyc.size(); i++) begin
            check_vec("t1_data", mon_data[i], word_val(i));
            check_vec("t1_port", mon_port[i], 2);
            check_vec("t1_sop_eop", mon_se[i], {i == 0, i == 2});
            check_vec("t1_latency", mon_cyc[i], drv_cyc[i] + 2);
        end
        check_vec("t1_idle", busy, 0);

        // ---- T2: all ready, 1-word grants, order from port 0 ----
        do_reset();
        for (int i = 0; i < N; i++) rsp_len[i] = 1;
        arb_en = 1'b1; port_ready = 4'b1111;
        wait_grants(5);
        port_ready = '0;
        cycles(10);
        exp_gr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_p  = '{0, 1, 2, 3, 0};
        check_vec("t2_out_count", mon_cyc.size(), 5);
        for (int i = 0; i < 5 && i < gr_val.size() && i < mon_port.size(); i++) begin
            check_vec("t2_grant",   gr_val[i],   exp_gr[i]);
            check_vec("t2_port",    mon_port[i], exp_p[i]);
            check_vec("t2_sop_eop", mon_se[i],   2'b11);
        end
        if (fall_cyc.size() >= 1 && gr_cyc.size() >= 2)
            check_vec("t2_gap", gr_cyc[1] - fall_cyc[0], 2);

        // ---- T3: continuous port 1 cut at 64 words, then port 2 ----
        // rr_ptr is 1 after the last T2 grant (port 0).
        clear_logs();
        rsp_len[1] = 1000; rsp_len[2] = 1;
        port_ready = 4'b0110;
        wait_grants(2);
        port_ready = '0;
        cycles(10);
        check_vec("t3_out_count", mon_cyc.size(), 65);
        if (gr_val.size() >= 2) begin
            check_vec("t3_grant0", gr_val[0], 4'b0010);
            check_vec("t3_grant1", gr_val[1], 4'b0100);
        end
        for (int i = 0; i < 64 && i < mon_cyc.size() && i < drv_cyc.size(); i++) begin
            check_vec("t3_data",    mon_data[i], word_val(i));
            check_vec("t3_sop_eop", mon_se[i],   {i == 0, i == 63});
            check_vec("t3_latency", mon_cyc[i],  drv_cyc[i] + 2);
        end
        if (drv_cyc.size() >= 64 && fall_cyc.size() >= 1)
            check_vec("t3_read_drop", fall_cyc[0], drv_cyc[63] + 1);
        if (gr_cyc.size() >= 2 && fall_cyc.size() >= 1)
            check_vec("t3_gap", gr_cyc[1] - fall_cyc[0], 2);
        if (mon_cyc.size() >= 65) begin
            check_vec("t3_p2_port",    mon_port[64], 2);
            check_vec("t3_p2_sop_eop", mon_se[64],   2'b11);
        end

        // ---- T4: grant port 3, no data returned ----
        do_reset();
        rsp_len[3] = 0; rsp_len[0] = 1;
        arb_en = 1'b1; port_ready = 4'b1000;
        wait_grants(1);
        port_ready = 4'b1001;
        cycles(22);
        check_vec("t4_no_output", mon_cyc.size(), 0);
`ifdef SW_ARB_TIMEOUT_EN
        check_vec("t4_tmo_count", tmo_cyc.size(), 1);
        if (tmo_cyc.size() >= 1 && gr_cyc.size() >= 1)
            check_vec("t4_tmo_cyc", tmo_cyc[0], gr_cyc[0] + 16);
        if (gr_val.size() >= 2) check_vec("t4_next_grant", gr_val[1], 4'b0001);
        else                    check_vec("t4_next_grant_seen", gr_val.size(), 2);
`else
        check_vec("t4_busy_held", busy, 1);
        check_vec("t4_read_held", port_read, 4'b1000);
        check_vec("t4_no_tmo", tmo_cyc.size(), 0);
`endif

        // ---- T5: reset during word 5 ----
        do_reset();
        rsp_len[2] = 1; rsp_len[0] = 1000;
        arb_en = 1'b1; port_ready = 4'b0100;
        wait_grants(1);
        port_ready = '0;
        cycles(8);                          // rr_ptr now 3
        clear_logs();
        port_ready = 4'b0001;
        wait_grants(1);
        port_ready = '0;
        k = 0;
        while (rsp_cnt < 5 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        check_vec("t5_word5_reached", rsp_cnt, 5);
        rst_n = 1'b0;
        #1;
        check_vec("t5_port_read", port_read, 4'b0000);
        check_vec("t5_out_valid", out_valid, 0);
        check_vec("t5_out_data",  out_data,  0);
        check_vec("t5_out_eop",   out_eop,   0);
        check_vec("t5_busy",      busy,      0);
        check_vec("t5_words_out", mon_cyc.size(), 3);
        for (int i = 0; i < mon_se.size(); i++) check_vec("t5_no_eop", mon_se[i][0], 0);
        cycles(2);
        clear_logs();
        rsp_len[0] = 1;
        rst_n = 1'b1;
        port_ready = 4'b1001;
        wait_grants(1);
        port_ready = '0;
        if (gr_val.size() >= 1) check_vec("t5_scan_from_0", gr_val[0], 4'b0001);
        cycles(8);

        // ---- T6: arb_en drops mid-burst ----
        do_reset();
        rsp_len[1] = 4;
        arb_en = 1'b1; port_ready = 4'b0010;
        wait_grants(1);
        arb_en = 1'b0;
        cycles(20);
        check_vec("t6_out_count", mon_cyc.size(), 4);
        if (mon_se.size() >= 4) check_vec("t6_eop", mon_se[3], 2'b01);
        check_vec("t6_no_regrant", gr_val.size(), 1);
        check_vec("t6_idle", busy, 0);
        check_vec("t6_read_low", port_read, 4'b0000);
        arb_en = 1'b1;
        wait_grants(2);
        port_ready = '0;
        if (gr_val.size() >= 2) check_vec("t6_regrant", gr_val[1], 4'b0010);
        cycles(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
